ball_axis_motion: RTL and testbench

// Single-axis ball position engine, parametrised for either screen axis (H or V).

---
 rtl/ball_axis_motion_pkg.sv | 13 +
 rtl/ball_axis_motion_beam_counter.sv | 29 ++
 rtl/ball_axis_motion.sv | 128 ++++++++++++
 tb/tb_ball_axis_motion.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_axis_motion_pkg.sv
// Shared constants for the ball axis engine: edge-handling modes and FSM state encodings.
package ball_axis_motion_pkg;

   localparam int unsigned EDGE_BOUNCE = 0;
   localparam int unsigned EDGE_WRAP   = 1;
   localparam int unsigned EDGE_CLAMP  = 2;

   typedef logic [0:0] state_t;

   localparam state_t S_IDLE = 1'b0;
   localparam state_t S_MOVE = 1'b1;

endpackage

// File: rtl/ball_axis_motion_beam_counter.sv
// Beam position along one axis: cleared on restart, advances one unit per visible cycle, saturates at p_LENGTH.
module ball_beam_counter #(
   parameter int unsigned p_LENGTH = 640,
   parameter int unsigned p_W      = $clog2(p_LENGTH + 1)
) (
   input  logic           i_Clk,
   input  logic           i_Rst_L,
   input  logic           i_Advance,
   input  logic           i_Restart,
   output logic [p_W-1:0] o_Cnt
);

   localparam logic [p_W-1:0] c_LAST = p_W'(p_LENGTH);

   logic [p_W-1:0] r_Cnt;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         r_Cnt <= '0;
      end else if (i_Restart) begin
         r_Cnt <= '0;
      end else if (i_Advance && (r_Cnt != c_LAST)) begin
         r_Cnt <= r_Cnt + p_W'(1);
      end
   end

   assign o_Cnt = r_Cnt;

endmodule

// File: rtl/ball_axis_motion.sv
// Single-axis ball position engine: per-frame motion burst with bounce/wrap/clamp edges and beam-overlap video.
module ball_axis_motion
   import ball_axis_motion_pkg::*;
#(
   parameter int unsigned p_LENGTH     = 640,
   parameter int unsigned p_BALL_SIZE  = 8,
   parameter int unsigned p_SPEED_BITS = 3,
   parameter int unsigned p_EDGE_MODE  = 0,
   parameter int unsigned p_START_DIR  = 1
) (
   input  logic                             i_Clk,
   input  logic                             i_Rst_L,
   input  logic                             i_Advance,
   input  logic                             i_Restart,
   input  logic                             i_Frame,
   input  logic [p_SPEED_BITS-1:0]          i_Speed,
   input  logic                             i_Dir_Load,
   input  logic                             i_Dir,
   input  logic                             i_Serve,
   output logic                             o_Video,
   output logic [$clog2(p_LENGTH+1)-1:0]    o_Pos,
   output logic                             o_Dir,
   output logic                             o_Hit_Lo,
   output logic                             o_Hit_Hi,
   output logic                             o_Busy
);

   localparam int unsigned W = $clog2(p_LENGTH + 1);
   localparam logic [W-1:0] c_MAX    = W'(p_LENGTH - p_BALL_SIZE);
   localparam logic [W-1:0] c_CENTER = W'((p_LENGTH - p_BALL_SIZE) / 2);
   localparam logic [W:0]   c_SIZE   = (W+1)'(p_BALL_SIZE);
   localparam logic         c_START_DIR = (p_START_DIR != 0);

   state_t                  r_State;
   logic [p_SPEED_BITS-1:0] r_Steps;
   logic [W-1:0]            r_Pos;
   logic                    r_Dir;
   logic                    r_Hit_Lo;
   logic                    r_Hit_Hi;

   logic [W-1:0] w_Cnt;
   logic         w_At_Hi;
   logic         w_At_Lo;
   logic [W-1:0] w_Next_Pos;
   logic         w_Abort;
   logic         w_Flip;

   ball_beam_counter #(
      .p_LENGTH (p_LENGTH),
      .p_W      (W)
   ) u_beam_counter (
      .i_Clk     (i_Clk),
      .i_Rst_L   (i_Rst_L),
      .i_Advance (i_Advance),
      .i_Restart (i_Restart),
      .o_Cnt     (w_Cnt)
   );

   // Extended by one bit so pos+size at p_LENGTH cannot overflow the compare.
   assign o_Video = i_Advance
                 && ({1'b0, w_Cnt} >= {1'b0, r_Pos})
                 && ({1'b0, w_Cnt} <  ({1'b0, r_Pos} + c_SIZE));

   assign w_At_Hi = r_Dir  && (r_Pos == c_MAX);
   assign w_At_Lo = !r_Dir && (r_Pos == '0);

   always_comb begin
      w_Next_Pos = r_Dir ? (r_Pos + W'(1)) : (r_Pos - W'(1));
      w_Abort    = 1'b0;
      w_Flip     = 1'b0;
      if (w_At_Hi || w_At_Lo) begin
         if (p_EDGE_MODE == EDGE_WRAP) begin
            w_Next_Pos = r_Dir ? '0 : c_MAX;
         end else if (p_EDGE_MODE == EDGE_CLAMP) begin
            w_Next_Pos = r_Pos;
            w_Abort    = 1'b1;
         end else begin
            w_Next_Pos = r_Dir ? (r_Pos - W'(1)) : (r_Pos + W'(1));
            w_Flip     = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L || i_Serve) begin
         r_State  <= S_IDLE;
         r_Steps  <= '0;
         r_Pos    <= c_CENTER;
         r_Dir    <= c_START_DIR;
         r_Hit_Lo <= 1'b0;
         r_Hit_Hi <= 1'b0;
      end else begin
         r_Hit_Lo <= 1'b0;
         r_Hit_Hi <= 1'b0;
         case (r_State)
            S_IDLE: begin
               if (i_Frame) begin
                  r_Steps <= i_Speed;
                  if (i_Speed != '0) r_State <= S_MOVE;
               end
            end
            S_MOVE: begin
               r_Pos    <= w_Next_Pos;
               r_Hit_Lo <= w_At_Lo;
               r_Hit_Hi <= w_At_Hi;
               if (w_Flip) r_Dir <= ~r_Dir;
               if (w_Abort) begin
                  r_Steps <= '0;
                  r_State <= S_IDLE;
               end else begin
                  r_Steps <= r_Steps - p_SPEED_BITS'(1);
                  if (r_Steps == p_SPEED_BITS'(1)) r_State <= S_IDLE;
               end
            end
            default: r_State <= S_IDLE;
         endcase
         // Last assignment wins: a load overrides a same-cycle bounce flip.
         if (i_Dir_Load) r_Dir <= i_Dir;
      end
   end

   assign o_Pos    = r_Pos;
   assign o_Dir    = r_Dir;
   assign o_Hit_Lo = r_Hit_Lo;
   assign o_Hit_Hi = r_Hit_Hi;
   assign o_Busy   = (r_State == S_MOVE);

endmodule

// File: tb/tb_ball_axis_motion.sv
// Self-checking bench: three instances (bounce, wrap, clamp) on shared stimulus against a per-burst reference model.
module tb_ball_axis_motion;

   localparam int LEN    = 16;
   localparam int SIZE   = 4;
   localparam int MAXP   = LEN - SIZE;
   localparam int CENTER = MAXP / 2;
   localparam int NM     = 3;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       adv = 1'b0;
   logic       restart = 1'b0;
   logic       frame = 1'b0;
   logic [2:0] speed = '0;
   logic       dir_load = 1'b0;
   logic       dir_in = 1'b0;
   logic       serve = 1'b0;

   logic       w_Video [NM];
   logic [4:0] w_Pos   [NM];
   logic       w_Dir   [NM];
   logic       w_Hit_Lo[NM];
   logic       w_Hit_Hi[NM];
   logic       w_Busy  [NM];

   int checks = 0;
   int failures = 0;

   int   m_pos [NM];
   logic m_dir [NM];
   logic m_act [NM];
   int   m_rem [NM];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NM; g++) begin : g_dut
      ball_axis_motion #(
         .p_LENGTH     (LEN),
         .p_BALL_SIZE  (SIZE),
         .p_SPEED_BITS (3),
         .p_EDGE_MODE  (g),
         .p_START_DIR  (1)
      ) u_dut (
         .i_Clk      (clk),
         .i_Rst_L    (rst_l),
         .i_Advance  (adv),
         .i_Restart  (restart),
         .i_Frame    (frame),
         .i_Speed    (speed),
         .i_Dir_Load (dir_load),
         .i_Dir      (dir_in),
         .i_Serve    (serve),
         .o_Video    (w_Video[g]),
         .o_Pos      (w_Pos[g]),
         .o_Dir      (w_Dir[g]),
         .o_Hit_Lo   (w_Hit_Lo[g]),
         .o_Hit_Hi   (w_Hit_Hi[g]),
         .o_Busy     (w_Busy[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_recentre();
      for (int m = 0; m < NM; m++) begin
         m_pos[m] = CENTER;
         m_dir[m] = 1'b1;
         m_act[m] = 1'b0;
         m_rem[m] = 0;
      end
   endtask

   // One unit of motion for mode m (0 bounce, 1 wrap, 2 clamp).
   task automatic model_step(input int m, output logic hl, output logic hh);
      hl = 1'b0;
      hh = 1'b0;
      if (m_dir[m] && m_pos[m] == MAXP) begin
         hh = 1'b1;
         if (m == 0) begin m_dir[m] = 1'b0; m_pos[m] = MAXP - 1; end
         else if (m == 1) m_pos[m] = 0;
         else m_act[m] = 1'b0;
      end else if (!m_dir[m] && m_pos[m] == 0) begin
         hl = 1'b1;
         if (m == 0) begin m_dir[m] = 1'b1; m_pos[m] = 1; end
         else if (m == 1) m_pos[m] = MAXP;
         else m_act[m] = 1'b0;
      end else begin
         m_pos[m] = m_dir[m] ? m_pos[m] + 1 : m_pos[m] - 1;
      end
      if (m_act[m]) begin
         m_rem[m]--;
         if (m_rem[m] == 0) m_act[m] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_l = 1'b0; frame = 1'b1; speed = 3'd5; dir_load = 1'b1; dir_in = 1'b0; serve = 1'b1;
      tick();
      tick();
      frame = 1'b0; dir_load = 1'b0; serve = 1'b0; speed = '0;
      model_recentre();
      for (int m = 0; m < NM; m++) begin
         checks++;
         if (int'(w_Pos[m]) !== CENTER || w_Dir[m] !== 1'b1 || w_Busy[m] !== 1'b0 ||
             w_Hit_Lo[m] !== 1'b0 || w_Hit_Hi[m] !== 1'b0 || w_Video[m] !== 1'b0) begin
            failures++;
            $display("FAIL reset[%0d]: pos=%0d dir=%b busy=%b hl=%b hh=%b vid=%b required pos=%0d dir=1 busy=0 hl=0 hh=0 vid=0",
                     m, w_Pos[m], w_Dir[m], w_Busy[m], w_Hit_Lo[m], w_Hit_Hi[m], w_Video[m], CENTER);
         end
      end
      rst_l = 1'b1;
      tick();
   endtask

   task automatic test_video();
      int c;
      logic e;
      adv = 1'b0;
      for (int m = 0; m < NM; m++) begin
         checks++;
         if (w_Video[m] !== 1'b0) begin
            failures++;
            $display("FAIL video_noadv[%0d]: got %b required 0", m, w_Video[m]);
         end
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      for (int k = 0; k < 40; k++) begin
         adv = 1'b1;
         #1;
         c = (k > LEN) ? LEN : k;
         for (int m = 0; m < NM; m++) begin
            e = (c >= m_pos[m]) && (c < m_pos[m] + SIZE);
            checks++;
            if (w_Video[m] !== e) begin
               failures++;
               $display("FAIL video[%0d] k=%0d pos=%0d: got %b required %b", m, k, m_pos[m], w_Video[m], e);
            end
         end
         tick();
      end
      adv = 1'b0;
   endtask

   task automatic test_serve();
      serve = 1'b1;
      tick();
      serve = 1'b0;
      model_recentre();
      for (int m = 0; m < NM; m++) begin
         checks++;
         if (int'(w_Pos[m]) !== CENTER || w_Dir[m] !== 1'b1 || w_Busy[m] !== 1'b0) begin
            failures++;
            $display("FAIL serve[%0d]: pos=%0d dir=%b busy=%b required pos=%0d dir=1 busy=0",
                     m, w_Pos[m], w_Dir[m], w_Busy[m], CENTER);
         end
      end
   endtask

   task automatic test_load_dir(input logic d);
      dir_load = 1'b1;
      dir_in = d;
      tick();
      dir_load = 1'b0;
      for (int m = 0; m < NM; m++) begin
         m_dir[m] = d;
         checks++;
         if (w_Dir[m] !== d) begin
            failures++;
            $display("FAIL dir_load[%0d]: got %b required %b", m, w_Dir[m], d);
         end
      end
   endtask

   // Frame pulse then one checked cycle per step; optional frame spam, dir load, serve or reset at a given step.
   task automatic test_burst(input int spd, input bit spam, input int ld_step, input logic ld_val,
                             input int srv_step, input int rst_step);
      logic hl, hh;
      frame = 1'b1;
      speed = 3'(spd);
      tick();
      frame = 1'b0;
      speed = '0;
      for (int m = 0; m < NM; m++) begin
         m_act[m] = (spd != 0);
         m_rem[m] = spd;
         checks++;
         if (w_Busy[m] !== m_act[m] || int'(w_Pos[m]) !== m_pos[m] ||
             w_Hit_Lo[m] !== 1'b0 || w_Hit_Hi[m] !== 1'b0) begin
            failures++;
            $display("FAIL burst_start[%0d]: busy=%b pos=%0d hl=%b hh=%b required busy=%b pos=%0d hl=0 hh=0",
                     m, w_Busy[m], w_Pos[m], w_Hit_Lo[m], w_Hit_Hi[m], m_act[m], m_pos[m]);
         end
      end
      for (int s = 1; s <= spd; s++) begin
         frame = spam;
         speed = spam ? 3'd7 : 3'd0;
         dir_load = (s == ld_step);
         dir_in = ld_val;
         serve = (s == srv_step);
         rst_l = !(s == rst_step);
         tick();
         frame = 1'b0; speed = '0; dir_load = 1'b0; serve = 1'b0; rst_l = 1'b1;
         for (int m = 0; m < NM; m++) begin
            hl = 1'b0;
            hh = 1'b0;
            if (s == srv_step || s == rst_step) begin
               m_pos[m] = CENTER; m_dir[m] = 1'b1; m_act[m] = 1'b0; m_rem[m] = 0;
            end else begin
               if (m_act[m]) model_step(m, hl, hh);
               if (s == ld_step) m_dir[m] = ld_val;
            end
            checks++;
            if (int'(w_Pos[m]) !== m_pos[m] || w_Dir[m] !== m_dir[m] || w_Busy[m] !== m_act[m] ||
                w_Hit_Lo[m] !== hl || w_Hit_Hi[m] !== hh) begin
               failures++;
               $display("FAIL burst_step[%0d] s=%0d: pos=%0d dir=%b busy=%b hl=%b hh=%b required pos=%0d dir=%b busy=%b hl=%b hh=%b",
                        m, s, w_Pos[m], w_Dir[m], w_Busy[m], w_Hit_Lo[m], w_Hit_Hi[m],
                        m_pos[m], m_dir[m], m_act[m], hl, hh);
            end
         end
      end
      tick();
      for (int m = 0; m < NM; m++) begin
         checks++;
         if (w_Busy[m] !== 1'b0 || w_Hit_Lo[m] !== 1'b0 || w_Hit_Hi[m] !== 1'b0 ||
             int'(w_Pos[m]) !== m_pos[m]) begin
            failures++;
            $display("FAIL burst_end[%0d]: busy=%b hl=%b hh=%b pos=%0d required busy=0 hl=0 hh=0 pos=%0d",
                     m, w_Busy[m], w_Hit_Lo[m], w_Hit_Hi[m], w_Pos[m], m_pos[m]);
         end
      end
   endtask

   task automatic test_edges();
      test_burst(3, 1'b0, 0, 1'b0, 0, 0);
      test_serve();
      test_burst(5, 1'b0, 0, 1'b0, 0, 0);
      test_burst(3, 1'b0, 0, 1'b0, 0, 0);
      test_serve();
      test_burst(6, 1'b0, 0, 1'b0, 0, 0);
      test_burst(1, 1'b0, 0, 1'b0, 0, 0);
      test_serve();
      test_load_dir(1'b0);
      test_burst(5, 1'b0, 0, 1'b0, 0, 0);
      test_burst(4, 1'b0, 0, 1'b0, 0, 0);
      test_video();
   endtask

   task automatic test_mid_burst();
      test_serve();
      test_burst(3, 1'b1, 0, 1'b0, 0, 0);
      test_serve();
      test_burst(6, 1'b0, 0, 1'b0, 0, 0);
      test_burst(1, 1'b0, 1, 1'b1, 0, 0);
      test_serve();
      test_burst(4, 1'b0, 0, 1'b0, 2, 0);
      test_burst(5, 1'b0, 0, 1'b0, 0, 3);
      test_burst(0, 1'b0, 0, 1'b0, 0, 0);
   endtask

   task automatic test_random();
      int spd, ld, srv;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1) test_load_dir(1'($urandom_range(0, 1)));
         spd = $urandom_range(0, 7);
         ld  = (spd > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, spd) : 0;
         srv = (spd > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, spd) : 0;
         test_burst(spd, 1'b0, ld, 1'($urandom_range(0, 1)), srv, 0);
         if (it % 6 == 5) test_video();
      end
   endtask

   initial begin
      model_recentre();
      test_reset();
      test_video();
      test_edges();
      test_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
